mem_responder: RTL and testbench

- Byte-wide memory target for the CPU's level-handshake memory bus; it is the responder end of the addr / memory_read_en / memory_write_en / memory_ready interface the CPU drives.
- Sits behind the shared bus and backs the operand stack, call stack and mapped ROM image.
- Provides configurable read wait states.
- Writes are posted and need no handshake.

---
 rtl/mem_responder.sv | 91 +++++++++
 tb/tb_mem_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: byte-wide level-handshake memory target with LATENCY read wait states and posted writes.
// Define MEM_BOUNDS_CHECK_EN to add a sticky err output; out-of-range writes are dropped, reads return 8'h00.
module mem_responder #(
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_access,
  input  logic [31:0] addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  input  logic        memory_read_en,
  input  logic        memory_write_en,
  output logic        memory_ready
`ifdef MEM_BOUNDS_CHECK_EN
  ,
  output logic        err
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT = 4'(LATENCY);
  typedef enum logic [1:0] {IDLE, WAIT, READY} state_t;
  state_t state, state_nxt;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] idx, a_lat;
  logic [3:0] cnt;
  logic rd, wr, same, oob, load, ready_nxt;
  logic [7:0] rdata, dout_nxt;
  assign idx = addr[AW-1:0];
`ifdef MEM_BOUNDS_CHECK_EN
  logic oob_lat;
  assign oob = |addr[31:AW];
  assign same = idx == a_lat && oob == oob_lat;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      oob_lat <= 1'b0;
      err <= 1'b0;
    end else begin
      if (load) oob_lat <= oob;
      if ((rd || wr) && oob) err <= 1'b1;
    end
`else
  logic unused_hi;
  assign unused_hi = ^addr[31:AW];
  assign oob = 1'b0;
  assign same = idx == a_lat;
`endif
  // X/Z on the enables falls through the if and reads as inactive
  always_comb begin
    rd = 1'b0;
    wr = 1'b0;
    if (mem_access && memory_read_en) rd = 1'b1;
    if (mem_access && memory_write_en) wr = 1'b1;
  end
  assign rdata = oob ? 8'h00 : mem[idx];
  always_ff @(posedge clk)
    if (wr && !oob) mem[idx] <= data_in;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      a_lat <= '0;
      memory_ready <= 1'b0;
      data_out <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt <= load ? LAT : cnt - {3'b000, state == WAIT};
      a_lat <= load ? idx : a_lat;
      memory_ready <= ready_nxt;
      data_out <= dout_nxt;
    end
  // load marks a (re)latch of the request address, which always restarts the wait count
  always_comb begin
    state_nxt = state;
    load = 1'b0;
    case (state)
      IDLE:  load = rd;
      WAIT:  if (!rd) state_nxt = IDLE; else if (!same) load = 1'b1; else if (cnt == 4'd1) state_nxt = READY;
      READY: if (!rd) state_nxt = IDLE; else if (!same) load = 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (load) state_nxt = LATENCY == 0 ? READY : WAIT;
  end
  // ready lags READY entry by one edge; data is sampled on entry and refreshed while held
  always_comb begin
    ready_nxt = state == READY && rd && same;
    dout_nxt = state_nxt == READY ? rdata : data_out;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: latencies 0..3 driven in parallel, checked against a run-length reference model.
`timescale 1ns/1ps
module tb_mem_responder;
  localparam int DEPTH = 1024;
  logic clk = 1'b0, rst_n = 1'b0, mem_access = 1'b0, rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] addr = '0;
  logic [7:0] data_in = '0;
  logic [3:0] rdy;
  logic [7:0] dout [4];
`ifdef MEM_BOUNDS_CHECK_EN
  logic [3:0] err;
`endif
  int checks = 0, errors = 0;
  logic [7:0] mdl [DEPTH];
  int run [4];
  logic [3:0] exp_rdy;
  logic [7:0] exp_dout [4];
  logic exp_err;
  logic [10:0] prev_key;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_responder #(.DEPTH(DEPTH), .LATENCY(g)) u_dut (
      .clk(clk), .rst_n(rst_n), .mem_access(mem_access), .addr(addr), .data_in(data_in),
      .data_out(dout[g]), .memory_read_en(rd_en), .memory_write_en(wr_en), .memory_ready(rdy[g])
`ifdef MEM_BOUNDS_CHECK_EN
      , .err(err[g])
`endif
    );
  end

  function automatic logic is_oob(logic [31:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
    return a >= DEPTH;
`else
    return a[31] & 1'b0;
`endif
  endfunction

  task automatic check(string tag, int i, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed %0h expected %0h", tag, i, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) run[i] = 0;
    exp_err = 1'b0;
    prev_key = '1;
  endtask

  // Ready is due once a read has been held at one location for LATENCY+2 consecutive edges.
  task automatic tick();
    bit r, w;
    logic [10:0] k;
    logic [7:0] v;
    @(posedge clk);
    r = mem_access && rd_en;
    w = mem_access && wr_en;
    k = {is_oob(addr), addr[9:0]};
    v = is_oob(addr) ? 8'h00 : mdl[addr[9:0]];
    for (int i = 0; i < 4; i++) begin
      run[i] = r ? ((k == prev_key) ? (run[i] < 64 ? run[i] + 1 : run[i]) : 1) : 0;
      exp_rdy[i] = run[i] >= i + 2;
      if (exp_rdy[i]) exp_dout[i] = v;
    end
    if ((r || w) && is_oob(addr)) exp_err = 1'b1;
    if (w && !is_oob(addr)) mdl[addr[9:0]] = data_in;
    prev_key = k;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("ready", i, rdy[i], exp_rdy[i]);
      if (exp_rdy[i]) check("data", i, dout[i], exp_dout[i]);
`ifdef MEM_BOUNDS_CHECK_EN
      check("err", i, err[i], exp_err);
`endif
    end
  endtask

  task automatic wait_ready(int i, output int n);
    n = 0;
    while (rdy[i] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("ready_timeout", i, rdy[i], 1);
  endtask

  initial begin
    int n;
    logic [7:0] v;
    model_reset();
    #12;
    for (int i = 0; i < 4; i++) begin
      check("reset_ready", i, rdy[i], 0);
      check("reset_dout", i, dout[i], 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_access = 1'b1;
    wr_en = 1'b1;
    for (int a = 0; a < 64; a++) begin
      addr = a;
      data_in = 8'($urandom);
      tick();
    end
    // write then read at LATENCY=1
    addr = 32'h10;
    data_in = 8'h5A;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick(); check("t1_e0", 1, rdy[1], 0);
    tick(); check("t1_e1", 1, rdy[1], 0);
    tick(); check("t1_e2", 1, rdy[1], 1); check("t1_data", 1, dout[1], 8'h5A);
    rd_en = 1'b0;
    tick(); check("t1_drop", 1, rdy[1], 0);
    // address change under held read at LATENCY=2
    wr_en = 1'b1; addr = 3; data_in = 8'h11; tick();
    addr = 4; data_in = 8'h22; tick();
    wr_en = 1'b0; rd_en = 1'b1; addr = 3;
    wait_ready(2, n); check("t2_data3", 2, dout[2], 8'h11);
    addr = 4;
    tick(); check("t2_drop", 2, rdy[2], 0);
    tick(); check("t2_low1", 2, rdy[2], 0);
    tick(); check("t2_low2", 2, rdy[2], 0);
    tick(); check("t2_rise", 2, rdy[2], 1); check("t2_data4", 2, dout[2], 8'h22);
    rd_en = 1'b0; tick();
    // abort in WAIT at LATENCY=3
    addr = 5; rd_en = 1'b1;
    tick(); check("t3_w0", 3, rdy[3], 0);
    tick(); check("t3_w1", 3, rdy[3], 0);
    rd_en = 1'b0;
    tick(); check("t3_abort", 3, rdy[3], 0);
    rd_en = 1'b1;
    wait_ready(3, n); check("t3_latency", 3, n, 5);
    rd_en = 1'b0; tick();
    // asynchronous reset during READY
    addr = 32'h10; rd_en = 1'b1;
    wait_ready(1, n);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rst_ready", i, rdy[i], 0);
      check("rst_dout", i, dout[i], 0);
    end
    #1 rst_n = 1'b1;
    wait_ready(1, n); check("t4_latency", 1, n, 3); check("t4_data", 1, dout[1], 8'h5A);
    rd_en = 1'b0; tick();
    // bus grant low gates both read and write
    v = mdl[10'h20];
    mem_access = 1'b0; rd_en = 1'b1; wr_en = 1'b1; addr = 32'h20; data_in = 8'hFF;
    repeat (4) begin
      tick();
      check("t5_gated", 0, rdy[0], 0);
    end
    wr_en = 1'b0; mem_access = 1'b1;
    wait_ready(0, n); check("t5_unchanged", 0, dout[0], v);
    rd_en = 1'b0; tick();
    // address 0x400: out of range with bounds checking, otherwise aliases to 0
    v = mdl[0];
    wr_en = 1'b1; addr = 32'h400; data_in = 8'h77; tick();
    wr_en = 1'b0; rd_en = 1'b1;
    wait_ready(1, n);
`ifdef MEM_BOUNDS_CHECK_EN
    check("t6_oob_data", 1, dout[1], 8'h00);
    check("t6_err", 1, err[1], 1);
    rd_en = 1'b0; tick();
    addr = 0; rd_en = 1'b1;
    wait_ready(1, n); check("t6_mem0", 1, dout[1], v);
`else
    check("t6_alias_data", 1, dout[1], 8'h77);
    rd_en = 1'b0; tick();
    addr = 0; rd_en = 1'b1;
    wait_ready(1, n); check("t6_alias_mem0", 1, dout[1], 8'h77);
`endif
    rd_en = 1'b0; tick();
    // randomized traffic over a small window so reads, writes and restarts collide
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(5) == 0) rd_en = ~rd_en;
      if ($urandom_range(7) == 0) begin
`ifdef MEM_BOUNDS_CHECK_EN
        addr = $urandom_range(15) | ($urandom_range(3) == 0 ? 32'h400 : 32'h0);
`else
        addr = $urandom_range(15) | ($urandom & 32'hFFFF_FC00);
`endif
      end
      wr_en = $urandom_range(3) == 0;
      data_in = 8'($urandom);
      mem_access = $urandom_range(15) != 0;
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
